// File: rtl/subtractor_pkg.sv
// ============================================================================
// Module : subtractor_pkg
// Brief  : Shared state encoding and defaults for the subtractor family.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package subtractor_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    // Encoding 2'd3 is unused and recovers to ST_IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_cell.sv
// ============================================================================
// Module : full_subtractor_cell
// Brief  : Combinational one-bit full subtractor (a - b - bin).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_seq.sv
// ============================================================================
// Module : serial_subtractor_seq
// Brief  : Bit-serial WIDTH-bit subtractor, D = A - B - Bin, LSB first.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_seq
    import subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    sub_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               w_diff;
    logic               w_br_next;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (w_diff),
        .bout (w_br_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_d = {w_diff, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = w_br_next;
                cnt_d = cnt_q + c_cnt_w'(1);
                // On the last bit a_q[0]/b_q[0] hold the original operand MSBs.
                if (cnt_q == c_last_cnt) begin
                    d_d     = {w_diff, res_q[WIDTH-1:1]};
                    bout_d  = w_br_next;
                    ovf_d   = (a_q[0] != b_q[0]) && (w_diff != a_q[0]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);
    assign d     = d_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_seq.sv
// ============================================================================
// Module : tb_serial_subtractor_seq
// Brief  : Self-checking bench for serial_subtractor_seq (WIDTH=8 and WIDTH=2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start2;
    logic [7:0] a_s, b_s;
    logic       bin_s;
    logic       sel2;

    logic       ready8, busy8, done8, bout8, ovf8;
    logic [7:0] d8;
    logic       ready2, busy2, done2, bout2, ovf2;
    logic [1:0] d2;

    logic       o_ready, o_busy, o_done, o_bout, o_ovf;
    logic [7:0] o_d;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] prev_d [2];

    always #5 clk = ~clk;

    serial_subtractor_seq #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a_s),
        .b     (b_s),
        .bin   (bin_s),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .bout  (bout8),
        .ovf   (ovf8)
    );

    serial_subtractor_seq #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a_s[1:0]),
        .b     (b_s[1:0]),
        .bin   (bin_s),
        .ready (ready2),
        .busy  (busy2),
        .done  (done2),
        .d     (d2),
        .bout  (bout2),
        .ovf   (ovf2)
    );

    assign o_ready = sel2 ? ready2 : ready8;
    assign o_busy  = sel2 ? busy2  : busy8;
    assign o_done  = sel2 ? done2  : done8;
    assign o_bout  = sel2 ? bout2  : bout8;
    assign o_ovf   = sel2 ? ovf2   : ovf8;
    assign o_d     = sel2 ? {6'b0, d2} : d8;

    // Reference: plain integer arithmetic, returns {bout, ovf, d}.
    function automatic logic [9:0] ref_sub(input int w, input int a, input int b, input int bn);
        int   m, diff, sa, sb, sd;
        logic [7:0] dv;
        logic bo, ov;
        m    = 1 << w;
        diff = a - b - bn;
        dv   = 8'((diff + m) % m);
        bo   = (a < b + bn);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sd   = sa - sb - bn;
        ov   = (sd < -(m / 2)) || (sd > m / 2 - 1);
        return {bo, ov, dv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel2) start2 = v;
        else      start8 = v;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bn,
                          input bit hold, input bit scramble);
        int         w;
        int         n;
        int         nb;
        logic [9:0] e;
        w = sel2 ? 2 : 8;
        e = ref_sub(w, int'(a), int'(b), int'(bn));
        check("ready_pre", 32'(o_ready), 32'd1);
        a_s   = a;
        b_s   = b;
        bin_s = bn;
        set_start(1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(1'b0);
        if (scramble) begin
            a_s = 8'hAA;
            b_s = 8'h11;
        end
        check("d_held", 32'(o_d), 32'(prev_d[sel2]));
        n  = 0;
        nb = 0;
        while (o_done !== 1'b1 && n < 40) begin
            if (o_busy === 1'b1) nb++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, w);
        check("busy_cycles", nb, w);
        check("d", 32'(o_d), 32'(e[7:0]));
        check("bout", 32'(o_bout), 32'(e[9]));
        check("ovf", 32'(o_ovf), 32'(e[8]));
        prev_d[sel2] = e[7:0];
        @(posedge clk); #1;
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("ready_post", 32'(o_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
        check({tag, "_d"},     32'(o_d),     32'd0);
        check({tag, "_bout"},  32'(o_bout),  32'd0);
        check({tag, "_ovf"},   32'(o_ovf),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        sel2      = 1'b0;
        start8    = 1'b0;
        start2    = 1'b0;
        a_s       = '0;
        b_s       = '0;
        bin_s     = 1'b0;
        prev_d[0] = '0;
        prev_d[1] = '0;
        rst       = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Start held high, operands changed during SHIFT; the next op only begins from IDLE.
        run_op(8'h05, 8'h03, 1'b0, 1'b1, 1'b1);
        run_op(8'hAA, 8'h11, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom_range(255)), 8'($urandom_range(255)),
                   1'($urandom_range(1)), 1'b0, 1'b0);
        end

        // Abort after the 4th SHIFT edge.
        a_s    = 8'h05;
        b_s    = 8'h03;
        bin_s  = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_abort");
        #1;
        rst       = 1'b0;
        prev_d[0] = '0;
        prev_d[1] = '0;
        ndone     = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_done === 1'b1) ndone++;
        end
        check("no_done_after_abort", ndone, 0);
        run_op(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);

        sel2 = 1'b1;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                for (int z = 0; z < 2; z++) begin
                    run_op(8'(x), 8'(y), 1'(z), 1'b0, 1'b0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor_seq.md
Name: serial_subtractor_seq

Overview:
- Bit-serial N-bit subtractor that computes D = A - B - Bin, one bit per clock, LSB first.
- Built around a single full-subtractor cell, the next stage up from the half subtractor. It is the first sequential arithmetic block in the subtractor family.
- Sits between an operand source (start/ready handshake) and a result consumer (single-cycle done pulse, held result).

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  initial borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT only.
- done  output  1  one-cycle pulse: the result outputs have just been updated.
- d  output  WIDTH  last completed difference; held until the next completion.
- bout  output  1  final borrow-out of the last completed operation.
- ovf  output  1  signed (two's-complement) overflow of the last completed operation.

Behaviour:
- Reset (rst=1, asynchronous, immediate):
  - State goes to IDLE; ready=1, busy=0, done=0, d=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset during SHIFT or DONE aborts the operation; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load a into the A shift register, b into the B shift register, bin into the borrow flop, and clear the counter. Go to SHIFT.
  - start=0 stays in IDLE.
- SHIFT: each edge processes bit 0 of the A and B shift registers with borrow br:
  - diff = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - diff shifts into the MSB of the result shift register; A and B shift right by one; the counter increments.
  - On the edge that processes bit WIDTH-1, and only then: d <= completed result, bout <= br_next, ovf <= (a[WIDTH-1] != b[WIDTH-1]) && (diff != a[WIDTH-1]), using the MSBs captured in the shift path. Go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - Start is accepted at edge E0; bits are processed at edges E1..E_WIDTH.
  - done is high between E_WIDTH and E_WIDTH+1.
  - ready is high again after E_WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
- start while busy=1 or in DONE is ignored. Changes to a, b or bin after the accepting edge have no effect.
- d, bout and ovf change only on the completion edge or on reset. They are stable for the consumer throughout the following operation.
- Arithmetic is modulo 2^WIDTH. bout=1 exactly when unsigned a < b + bin.
- Counter width is clog2(WIDTH) bits. The terminal count is WIDTH-1, with no wrap-around use.

Decomposition:
- Shared package (subtractor_pkg):
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
  - Default width constant SUB_WIDTH_DEFAULT=8.
- Sub-module full_subtractor_cell: purely combinational, outputs (diff, bout), inputs (a, b, bin), implementing the equations above. Instantiated once.
- The FSM, counter and shift registers live in the top module.

Test Plan:
- Reset: rst=1 mid-cycle with no clock edge -> ready=1, busy=0, done=0, d=8'h00, bout=0, ovf=0 immediately.
- a=8'h05, b=8'h03, bin=0, start pulse -> busy for 8 cycles, then done for exactly 1 cycle with d=8'h02, bout=0, ovf=0; ready=1 on the next cycle.
- a=8'h03, b=8'h05, bin=0 -> d=8'hFE, bout=1, ovf=0. Then a=8'h00, b=8'h00, bin=1 -> d=8'hFF, bout=1, ovf=0.
- a=8'h80, b=8'h01, bin=0 -> d=8'h7F, bout=0, ovf=1. Then a=8'h7F, b=8'hFF -> d=8'h80, bout=1, ovf=1.
- Start held high continuously with a/b changed to 8'hAA/8'h11 during SHIFT -> first result unaffected; one done per operation; the next operation starts only from IDLE.
- rst asserted after the 4th SHIFT edge of a=8'h05, b=8'h03 -> outputs zero at once, no done. Then a new op a=8'h10, b=8'h01 -> d=8'h0F. Finish with an exhaustive WIDTH=2 sweep of all a, b, bin against a reference model.
